// File: rtl/sweep_pkg.sv
// Shared state type, sizes and drive-order function for the minterm sweeper.
// Defining SWEEP_GRAY_EN switches vec() from binary to Gray drive order.
package sweep_pkg;

  localparam int unsigned VEC_N = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2
  } state_e;

  // Maps sweep position to the minterm driven at that position.
  function automatic logic [IDX_W-1:0] vec(input logic [IDX_W-1:0] idx);
`ifdef SWEEP_GRAY_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/minterm_settle_timer.sv
// Loadable 4-bit down-counter with terminal-count flag; sets the HOLD dwell.
// tc_o is high whenever the count has reached zero.
module minterm_settle_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       tc_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/minterm_sweeper.sv
// Drives all 16 input vectors into a 4-input function, captures its truth table
// and checks it against EXPECTED. SWEEP_GRAY_EN selects Gray drive order.
module minterm_sweeper
  import sweep_pkg::*;
#(
  parameter logic [15:0] EXPECTED = 16'h325A,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        x_o,
  output logic        y_o,
  output logic        w_o,
  output logic        z_o,
  input  logic        s_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] table_o,
  output logic        pass_o,
  output logic [4:0]  err_count_o,
  output logic [3:0]  first_err_o
);

  localparam logic [3:0] SETTLE_V = SETTLE[3:0];

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] vec_q;
  logic [VEC_N-1:0] table_q;
  logic [4:0]       err_q;
  logic [3:0]       ferr_q;
  logic             pass_q;
  logic             busy_q;
  logic             done_q;

  logic [IDX_W-1:0] cur_m_d;
  logic             s_known_d;
  logic             s_bit_d;
  logic             miss_d;
  logic [4:0]       err_d;
  logic             load_d;
  logic             settle_tc;

  // An unknown sample is stored as 0 and always counted as a mismatch.
  always_comb begin
    cur_m_d   = vec(idx_q);
    s_known_d = (s_i === 1'b0) || (s_i === 1'b1);
    s_bit_d   = s_known_d & s_i;
    miss_d    = !s_known_d || (s_i != EXPECTED[cur_m_d]);
    err_d     = err_q + {4'd0, miss_d};
    load_d    = ((state_q == IDLE) && start_i) ||
                ((state_q == SAMPLE) && (idx_q != '1));
  end

  minterm_settle_timer u_settle (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_d),
    .load_val_i (SETTLE_V),
    .en_i       (state_q == HOLD),
    .tc_o       (settle_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      table_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= HOLD;
            idx_q   <= '0;
            vec_q   <= vec('0);
            table_q <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (settle_tc) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_q[cur_m_d] <= s_bit_d;
          err_q            <= err_d;
          if (miss_d && ((err_q == '0) || (cur_m_d < ferr_q))) begin
            ferr_q <= cur_m_d;
          end
          if (idx_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            vec_q   <= '0;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= HOLD;
            idx_q   <= idx_q + 4'd1;
            vec_q   <= vec(idx_q + 4'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {x_o, y_o, w_o, z_o} = vec_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign table_o     = table_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign first_err_o = ferr_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Self-checking bench for minterm_sweeper: two instances (SETTLE=1 and SETTLE=0)
// sweep directed and random truth-table functions; honours SWEEP_GRAY_EN.
module tb_minterm_sweeper;

  localparam logic [15:0] EXP = 16'h325A;

`ifdef SWEEP_GRAY_EN
  localparam int ORD [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
`else
  localparam int ORD [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] fn_mask = EXP;

  logic        xa, ya, wa, za, sa, busya, donea, passa;
  logic [15:0] tbla;
  logic [4:0]  erra;
  logic [3:0]  ferra;
  logic        xb, yb, wb, zb, sb, busyb, doneb, passb;
  logic [15:0] tblb;
  logic [4:0]  errb;
  logic [3:0]  ferrb;

  int n_cmp  = 0;
  int n_fail = 0;

  // Function under test: a truth-table lookup on the driven vector.
  assign sa = fn_mask[{xa, ya, wa, za}];
  assign sb = fn_mask[{xb, yb, wb, zb}];

  always #5 clk = ~clk;

  minterm_sweeper #(.EXPECTED(EXP), .SETTLE(1)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .x_o(xa), .y_o(ya), .w_o(wa), .z_o(za), .s_i(sa),
    .busy_o(busya), .done_o(donea), .table_o(tbla), .pass_o(passa),
    .err_count_o(erra), .first_err_o(ferra)
  );

  minterm_sweeper #(.EXPECTED(EXP), .SETTLE(0)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .x_o(xb), .y_o(yb), .w_o(wb), .z_o(zb), .s_i(sb),
    .busy_o(busyb), .done_o(doneb), .table_o(tblb), .pass_o(passb),
    .err_count_o(errb), .first_err_o(ferrb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_errs(input logic [15:0] m);
    int c = 0;
    for (int i = 0; i < 16; i++) if (m[i] != EXP[i]) c++;
    return c;
  endfunction

  function automatic int ref_first(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i] != EXP[i]) return i;
    return 0;
  endfunction

  task automatic check_results(input string name, input logic [15:0] m);
    check({name, ".tableA"}, tbla, m);
    check({name, ".passA"},  passa, (m == EXP));
    check({name, ".errA"},   erra, ref_errs(m));
    check({name, ".ferrA"},  ferra, ref_first(m));
    check({name, ".tableB"}, tblb, m);
    check({name, ".passB"},  passb, (m == EXP));
    check({name, ".errB"},   errb, ref_errs(m));
    check({name, ".ferrB"},  ferrb, ref_first(m));
  endtask

  task automatic check_zero(input string name);
    check({name, ".busyA"}, busya, 0);
    check({name, ".doneA"}, donea, 0);
    check({name, ".vecA"},  {xa, ya, wa, za}, 0);
    check({name, ".tableA"}, tbla, 0);
    check({name, ".passA"}, passa, 0);
    check({name, ".errA"},  erra, 0);
    check({name, ".ferrA"}, ferra, 0);
    check({name, ".busyB"}, busyb, 0);
    check({name, ".tableB"}, tblb, 0);
  endtask

  // One complete sweep on both instances, observed for a fixed window.
  task automatic run_sweep(input string name, input logic [15:0] m, input bit repulse);
    int ba = 0, bb = 0, da = 0, db = 0, na = 0, nb = 0, ga = 0, gb = 0;
    int lasta = -1, lastb = -1, va, vb;
    int oa [16];
    int ob [16];
    fn_mask = m;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 120; c++) begin
      va = int'({xa, ya, wa, za});
      vb = int'({xb, yb, wb, zb});
      if (busya) begin
        ba++;
        if (va != lasta) begin
          if (na < 16) oa[na] = va;
          na++;
          lasta = va;
        end
      end
      if (busyb) begin
        bb++;
        if (vb != lastb) begin
          if (nb < 16) ob[nb] = vb;
          nb++;
          lastb = vb;
        end
      end
      if (donea) da++;
      if (doneb) db++;
      if (repulse && c == 10) start = 1'b1;
      if (repulse && c == 11) start = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      if (i < na && oa[i] == ORD[i]) ga++;
      if (i < nb && ob[i] == ORD[i]) gb++;
    end
    check({name, ".busylenA"}, ba, 48);
    check({name, ".busylenB"}, bb, 32);
    check({name, ".donesA"}, da, 1);
    check({name, ".donesB"}, db, 1);
    check({name, ".nvecA"}, na, 16);
    check({name, ".orderA"}, ga, 16);
    check({name, ".orderB"}, gb, 16);
    check_results(name, m);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rm;
    int c;

    #1;
    check_zero("reset0");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_sweep("good",   EXP,              1'b0);
    run_sweep("fault6", EXP ^ 16'h0040,   1'b0);
    check("fault6.tableLit", tbla, 16'h321A);
    run_sweep("stuck0", 16'h0000,         1'b0);
    check("stuck0.errLit", erra, 7);
    check("stuck0.ferrLit", ferra, 1);
    run_sweep("ones",   16'hFFFF,         1'b0);
    run_sweep("repulse", EXP,             1'b1);

    // start held high through done: a new sweep begins right away with a cleared table
    fn_mask = EXP;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    c = 0;
    while (c < 100 && !donea) begin
      @(negedge clk);
      c++;
    end
    check("hold.doneA", donea, 1);
    check("hold.tableAtDone", tbla, EXP);
    @(negedge clk);
    check("hold.rebusyA", busya, 1);
    check("hold.clearedA", tbla, 0);
    start = 1'b0;
    repeat (120) @(negedge clk);
    check("hold.finalA", tbla, EXP);
    check("hold.passA", passa, 1);

    // asynchronous reset during HOLD of sweep position 5
    fn_mask = EXP ^ 16'h0002;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0;
    while (c < 100 && !(busya && int'({xa, ya, wa, za}) == ORD[5])) begin
      @(negedge clk);
      c++;
    end
    check("midrst.reachedA", busya, 1);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk); rst = 1'b0;
    run_sweep("postrst", EXP, 1'b0);

    for (int k = 0; k < 4; k++) begin
      rm = 16'($urandom);
      run_sweep($sformatf("rnd%0d", k), rm, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
